// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalize-and-round stage.
//
// Contents:
//    state_t        control FSM encoding (S_IDLE, S_NORM, S_ROUND, S_DONE)
//    EXP_BIAS       IEEE-754 single-precision exponent bias
//    EXP_MAX        all-ones exponent (infinity / NaN field value)
//    EXP_MIN_NORM   smallest exponent a normal number can carry
//    HIDDEN/GUARD/ROUND  bit positions inside the 26-bit working mantissa
package fp_pkg;

    // States carry an S_ prefix so they do not collide with the ROUND bit position
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int         EXP_BIAS     = 127;
    localparam logic [7:0] EXP_MAX      = 8'hFF;
    localparam logic [7:0] EXP_MIN_NORM = 8'd1;

    localparam int HIDDEN = 25;
    localparam int GUARD  = 1;
    localparam int ROUND  = 0;

endpackage

// File: rtl/fp_round_ne.sv
// Combinational round-to-nearest-even and packing for a normalized (or
// subnormal) working mantissa.
//
// Ports:
//    sign_i      result sign
//    exp_i       biased exponent of the working mantissa
//    man_i       working mantissa {hidden, frac[22:0], guard, round}
//    sticky_i    OR of every bit already shifted out below round
//    packed_o    {sign, exp, frac} single-precision word
//    inexact_o   guard|round|sticky was nonzero
//    overflow_o  rounding pushed the exponent to all-ones
module fp_round_ne
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 26,
    parameter int FRAC_W = MAN_W - 3
) (
    input  logic                      sign_i,
    input  logic [EXP_W-1:0]          exp_i,
    input  logic [MAN_W-1:0]          man_i,
    input  logic                      sticky_i,
    output logic [EXP_W+FRAC_W:0]     packed_o,
    output logic                      inexact_o,
    output logic                      overflow_o
);

    logic               guardBit;
    logic               roundBit;
    logic               lsbBit;
    logic               roundUp;
    logic [MAN_W-2:0]   upper;
    logic               carry;
    logic               hiddenOut;
    logic [EXP_W:0]     expRounded;
    logic [EXP_W:0]     expField;

    // The increment is applied only to the bits at and above the LSB, with one
    // spare bit on top to catch the carry out of the hidden position. When that
    // carry happens the mantissa was all ones, so the fraction bits are already
    // zero and the result is exactly 1.0 with the exponent bumped.
    always_comb begin
        guardBit   = man_i[GUARD];
        roundBit   = man_i[ROUND];
        lsbBit     = man_i[GUARD+1];
        roundUp    = guardBit & (roundBit | sticky_i | lsbBit);
        upper      = {1'b0, man_i[MAN_W-1:GUARD+1]} + {{(MAN_W-2){1'b0}}, roundUp};
        carry      = upper[MAN_W-2];
        hiddenOut  = carry | upper[MAN_W-3];
        expRounded = {1'b0, exp_i} + {{EXP_W{1'b0}}, carry};
        // Subnormals pack with a zero exponent; a subnormal that rounds into the
        // hidden bit simply becomes the smallest normal.
        expField   = hiddenOut ? expRounded : '0;
        overflow_o = (expField >= {1'b0, EXP_MAX});
        inexact_o  = guardBit | roundBit | sticky_i;
        if (overflow_o) begin
            packed_o = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            packed_o = {sign_i, expField[EXP_W-1:0], upper[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalize-and-round stage placed after the add/sub mantissa stage.
// One left shift per cycle until the hidden bit is set (or the exponent reaches
// the subnormal floor), then a single round-to-nearest-even cycle, then the
// result is held until the consumer takes it. One operation in flight.
//
// Ports:
//    clk, rst_n              clock, asynchronous active-low reset
//    in_valid / in_ready     upstream handshake
//    in_sign, in_exp         sign and biased exponent from the adder
//    in_mantis, in_loss      26-bit sum mantissa and sticky bit
//    in_operator             1 = effective subtraction
//    out_valid / out_ready   downstream handshake
//    out_result              packed {sign, exp[7:0], frac[22:0]}
//    out_inexact, out_overflow, out_zero   status flags
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 26,
    parameter int FRAC_W = MAN_W - 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [MAN_W-1:0]      in_mantis,
    input  logic                  in_loss,
    input  logic                  in_operator,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_result,
    output logic                  out_inexact,
    output logic                  out_overflow,
    output logic                  out_zero
);

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic [MAN_W-1:0]       man_q, man_d;
    logic                   loss_q, loss_d;
    logic                   op_q, op_d;
    logic                   inf_q, inf_d;
    logic [EXP_W+FRAC_W:0]  result_q, result_d;
    logic                   inexact_q, inexact_d;
    logic                   overflow_q, overflow_d;
    logic                   zero_q, zero_d;

    logic [EXP_W+FRAC_W:0]  rndPacked;
    logic                   rndInexact;
    logic                   rndOverflow;

    fp_round_ne #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .sign_i     (sign_q),
        .exp_i      (exp_q),
        .man_i      (man_q),
        .sticky_i   (loss_q),
        .packed_o   (rndPacked),
        .inexact_o  (rndInexact),
        .overflow_o (rndOverflow)
    );

    // State and datapath registers; reset clears everything so an aborted
    // operation leaves no trace on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            man_q      <= '0;
            loss_q     <= 1'b0;
            op_q       <= 1'b0;
            inf_q      <= 1'b0;
            result_q   <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            man_q      <= man_d;
            loss_q     <= loss_d;
            op_q       <= op_d;
            inf_q      <= inf_d;
            result_q   <= result_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    // Next-state and datapath control. Everything holds by default; each state
    // only overrides what it changes.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        man_d      = man_q;
        loss_d     = loss_q;
        op_d       = op_q;
        inf_d      = inf_q;
        result_d   = result_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    man_d   = in_mantis;
                    loss_d  = in_loss;
                    op_d    = in_operator;
                    inf_d   = 1'b0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (man_q == '0) begin
                    // x - x yields +0; a zero from addition keeps its sign
                    if (op_q) begin
                        sign_d = 1'b0;
                    end
                    state_d = S_ROUND;
                end else if (exp_q == EXP_MAX) begin
                    inf_d   = 1'b1;
                    state_d = S_ROUND;
                end else if (man_q[HIDDEN]) begin
                    state_d = S_ROUND;
                end else if (exp_q <= EXP_MIN_NORM) begin
                    // Exponent floor reached: leave it as a subnormal
                    state_d = S_ROUND;
                end else begin
                    man_d = {man_q[MAN_W-2:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end
            end
            S_ROUND: begin
                if (inf_q) begin
                    result_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    inexact_d  = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    result_d   = rndPacked;
                    inexact_d  = rndInexact;
                    overflow_d = rndOverflow;
                end
                zero_d  = (result_d[EXP_W+FRAC_W-1:0] == '0);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_result   = result_q;
    assign out_inexact  = inexact_q;
    assign out_overflow = overflow_q;
    assign out_zero     = zero_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed operands, a value-level model of
// normalize + round-to-nearest-even, a per-cycle compare process while the
// result is presented, and literal expectations for each directed operand.
module tb_fp_norm_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [25:0] in_mantis;
    logic        in_loss;
    logic        in_operator;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_inexact;
    logic        out_overflow;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    logic [31:0] expResult;
    bit          expInexact;
    bit          expOverflow;
    bit          expZero;
    bit          expArmed = 1'b0;
    int          expLat;

    logic [31:0] gotResult;
    logic        gotInexact;
    logic        gotOverflow;
    logic        gotZero;
    int          gotLat;

    fp_norm_round dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mantis    (in_mantis),
        .in_loss      (in_loss),
        .in_operator  (in_operator),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value-level model: normalize by doubling until the value is at least
    // 2^25 (or the exponent floor), then round the quotient by 4 to nearest even.
    function automatic void modelCompute(input bit sgn, input int e, input longint m,
                                         input bit loss, input bit op,
                                         output logic [31:0] res, output bit inex,
                                         output bit ovf, output bit zer, output int lat);
        longint     mm;
        longint     q;
        int         ee;
        int         k;
        int         rem;
        int         expField;
        bit         s;
        logic [7:0] ef;
        logic [22:0] fr;
        mm   = m;
        ee   = e;
        k    = 0;
        s    = sgn;
        ovf  = 1'b0;
        inex = 1'b0;
        if (m == 0) begin
            if (op) s = 1'b0;
            res  = {s, 31'd0};
            inex = loss;
            zer  = 1'b1;
            lat  = 2;
            return;
        end
        if (e == 255) begin
            res = {s, 8'hFF, 23'd0};
            zer = 1'b0;
            lat = 2;
            return;
        end
        while (mm < (64'd1 << 25) && ee > 1) begin
            mm = mm * 2;
            ee = ee - 1;
            k  = k + 1;
        end
        q   = mm / 4;
        rem = int'(mm % 4);
        if (rem == 3 || (rem == 2 && (loss || (q % 2) == 1))) q = q + 1;
        inex = (rem != 0) || loss;
        if (q >= (64'd1 << 24)) begin
            q  = q / 2;
            ee = ee + 1;
        end
        expField = (q >= (64'd1 << 23)) ? ee : 0;
        if (expField >= 255) begin
            res = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            ef  = expField[7:0];
            fr  = q[22:0];
            res = {s, ef, fr};
        end
        zer = (res[30:0] == 31'd0);
        lat = k + 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one operand at the falling edge and hold it through the accepting edge
    task automatic applyStimulus(input bit sgn, input logic [7:0] e, input logic [25:0] m,
                                 input bit loss, input bit op);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("inReadyBeforeAccept", 32'(in_ready), 32'd1);
        in_sign     = sgn;
        in_exp      = e;
        in_mantis   = m;
        in_loss     = loss;
        in_operator = op;
        in_valid    = 1'b1;
        modelCompute(sgn, int'(e), longint'(m), loss, op,
                     expResult, expInexact, expOverflow, expZero, expLat);
        expArmed = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count cycles to out_valid, capture, optionally stall, then complete the handshake
    task automatic waitResult(input int readyDelay);
        int lat;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        gotLat      = lat;
        gotResult   = out_result;
        gotInexact  = out_inexact;
        gotOverflow = out_overflow;
        gotZero     = out_zero;
        repeat (readyDelay) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("validDropsAfterReady", 32'(out_valid), 32'd0);
        checkOutput("inReadyRisesAfterReady", 32'(in_ready), 32'd1);
        expArmed = 1'b0;
    endtask

    // Every cycle a result is presented it must match the model and hold in_ready low
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (!expArmed) begin
                checkOutput("unexpectedValid", 32'(out_valid), 32'd0);
            end else begin
                checkOutput("modelResult", out_result, expResult);
                checkOutput("modelInexact", 32'(out_inexact), 32'(expInexact));
                checkOutput("modelOverflow", 32'(out_overflow), 32'(expOverflow));
                checkOutput("modelZero", 32'(out_zero), 32'(expZero));
                checkOutput("inReadyLowWhileValid", 32'(in_ready), 32'd0);
            end
        end
    end

    initial begin
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exp      = '0;
        in_mantis   = '0;
        in_loss     = 1'b0;
        in_operator = 1'b0;
        out_ready   = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("resetInReady", 32'(in_ready), 32'd1);
        checkOutput("resetOutValid", 32'(out_valid), 32'd0);
        checkOutput("resetResult", out_result, 32'd0);
        checkOutput("resetFlags", {29'd0, out_inexact, out_overflow, out_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0, already normalized
        applyStimulus(1'b0, 8'd127, 26'h2000000, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("oneResult", gotResult, 32'h3F800000);
        checkOutput("oneInexact", 32'(gotInexact), 32'd0);
        checkOutput("oneLatency", 32'(gotLat), 32'd2);

        // Four shifts to 0.5
        applyStimulus(1'b0, 8'd130, 26'h0200000, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("halfResult", gotResult, 32'h3F000000);
        checkOutput("halfLatency", 32'(gotLat), 32'd6);

        // x - x gives +0 even with a negative latched sign
        applyStimulus(1'b1, 8'd127, 26'h0000000, 1'b0, 1'b1);
        waitResult(0);
        checkOutput("subZeroResult", gotResult, 32'h00000000);
        checkOutput("subZeroFlag", 32'(gotZero), 32'd1);

        // Zero from addition keeps its sign
        applyStimulus(1'b1, 8'd127, 26'h0000000, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("negZeroResult", gotResult, 32'h80000000);

        // All ones rounds up with carry into the exponent
        applyStimulus(1'b0, 8'd127, 26'h3FFFFFF, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("carryResult", gotResult, 32'h40000000);
        checkOutput("carryInexact", 32'(gotInexact), 32'd1);

        // Exact tie with even LSB stays put; sticky breaks the tie upward
        applyStimulus(1'b0, 8'd127, 26'h2000002, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("tieEvenResult", gotResult, 32'h3F800000);
        checkOutput("tieEvenInexact", 32'(gotInexact), 32'd1);
        applyStimulus(1'b0, 8'd127, 26'h2000002, 1'b1, 1'b0);
        waitResult(0);
        checkOutput("tieStickyResult", gotResult, 32'h3F800001);

        // Rounding out of the top exponent becomes infinity
        applyStimulus(1'b0, 8'd254, 26'h3FFFFFF, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("ovfResult", gotResult, 32'h7F800000);
        checkOutput("ovfFlag", 32'(gotOverflow), 32'd1);

        // Shifts stop at exponent 1 and pack as subnormal
        applyStimulus(1'b0, 8'd3, 26'h0100000, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("subnormResult", gotResult, 32'h00100000);
        checkOutput("subnormLatency", 32'(gotLat), 32'd4);

        // Subnormal that rounds into the hidden bit becomes the smallest normal
        applyStimulus(1'b0, 8'd1, 26'h1FFFFFE, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("subToNormResult", gotResult, 32'h00800000);

        // Maximum shift count
        applyStimulus(1'b1, 8'd100, 26'h0000001, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("maxShiftResult", gotResult, 32'hA5800000);
        checkOutput("maxShiftLatency", 32'(gotLat), 32'd27);

        // Backpressure: result must hold for five stalled cycles
        applyStimulus(1'b1, 8'd128, 26'h2000003, 1'b0, 1'b0);
        waitResult(5);
        checkOutput("stallResult", gotResult, 32'hC0000001);

        // Reset while normalizing aborts the operation
        applyStimulus(1'b1, 8'd100, 26'h0000001, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        expArmed = 1'b0;
        #1;
        checkOutput("abortOutValid", 32'(out_valid), 32'd0);
        checkOutput("abortResult", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("readyAfterRelease", 32'(in_ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 checkOutput("noEmitAfterAbort", 32'(out_valid), 32'd0);
        end

        // Recovery after the abort
        applyStimulus(1'b0, 8'd127, 26'h2000000, 1'b0, 1'b0);
        waitResult(0);
        checkOutput("recoverResult", gotResult, 32'h3F800000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
